// File: rtl/ast_tensor_job_sequencer.sv
// ast_tensor_job_sequencer: runs one matrix-multiply job by programming the DMA
// register file (load A, load B, store C) around a tensor start/done handshake.
`default_nettype none

module ast_tensor_job_sequencer #(
    parameter int SIZE      = 4,
    parameter int DATAWIDTH = 14,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [DATAWIDTH-1:0]       addr_a,
    input  logic [DATAWIDTH-1:0]       addr_b,
    input  logic [DATAWIDTH-1:0]       addr_c,
    input  logic [$clog2(SIZE):0]      dim,
    input  logic                       relu_en,
    output logic                       dma_write,
    output logic [2:0]                 dma_select,
    output logic [DATAWIDTH-1:0]       dma_data,
    input  logic                       dma_fin_transfer,
    output logic                       tensor_start,
    output logic                       tensor_relu,
    input  logic                       tensor_done,
    output logic                       job_busy,
    output logic                       job_done,
    output logic [1:0]                 job_err
);

    localparam int DW = $clog2(SIZE) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DIM_MAX  = DW'(SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT_DMA, S_START, S_WAIT_T, S_DONE
    } state_t;

    state_t               state, state_n;
    logic [1:0]           phase, phase_n;
    logic [2:0]           idx, idx_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [DW-1:0]        dim_q, dim_n;
    logic [DATAWIDTH-1:0] a_q, a_n, b_q, b_n, c_q, c_n;
    logic                 relu_q, relu_n;
    logic [1:0]           err_n;
    logic [2:0]           sel_c;
    logic [DATAWIDTH-1:0] data_c, base_c;
    logic                 wr_n;

    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        cnt_n   = cnt;
        dim_n   = dim_q;
        a_n     = a_q;
        b_n     = b_q;
        c_n     = c_q;
        relu_n  = relu_q;
        err_n   = job_err;
        case (state)
            S_IDLE: begin
                if (job_valid) begin
                    dim_n   = dim;
                    a_n     = addr_a;
                    b_n     = addr_b;
                    c_n     = addr_c;
                    relu_n  = relu_en;
                    phase_n = 2'd0;
                    idx_n   = 3'd0;
                    if (dim == '0 || dim > DIM_MAX) begin
                        state_n = S_DONE;
                        err_n   = 2'd1;
                    end else begin
                        state_n = S_WRITE;
                        err_n   = 2'd0;
                    end
                end
            end
            S_WRITE: begin
                if (idx == 3'd4) begin
                    state_n = S_WAIT_DMA;
                    cnt_n   = '0;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            // The first wait cycle (cnt==0) still shows the previous transfer's status.
            S_WAIT_DMA: begin
                if (cnt != '0 && dma_fin_transfer) begin
                    case (phase)
                        2'd0: begin
                            state_n = S_WRITE;
                            phase_n = 2'd1;
                            idx_n   = 3'd0;
                        end
                        2'd1:    state_n = S_START;
                        default: state_n = S_DONE;
                    endcase
                end else if (cnt == CNT_LAST) begin
                    state_n = S_DONE;
                    err_n   = 2'd2;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_START: begin
                state_n = S_WAIT_T;
                cnt_n   = '0;
            end
            S_WAIT_T: begin
                if (cnt != '0 && tensor_done) begin
                    state_n = S_WRITE;
                    phase_n = 2'd2;
                    idx_n   = 3'd0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_DONE;
                    err_n   = 2'd3;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        case (phase_n)
            2'd0:    base_c = a_n;
            2'd1:    base_c = b_n;
            default: base_c = c_n;
        endcase
        // Register order is depth, width, mode, address, then go (select 3) last.
        case (idx_n)
            3'd0:    begin sel_c = 3'd0; data_c = DATAWIDTH'(dim_n);   end
            3'd1:    begin sel_c = 3'd1; data_c = DATAWIDTH'(dim_n);   end
            3'd2:    begin sel_c = 3'd2; data_c = DATAWIDTH'(phase_n); end
            3'd3:    begin sel_c = 3'd4; data_c = base_c;              end
            default: begin sel_c = 3'd3; data_c = DATAWIDTH'(1);       end
        endcase
        wr_n = (state_n == S_WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            phase        <= 2'd0;
            idx          <= 3'd0;
            cnt          <= '0;
            dim_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            relu_q       <= 1'b0;
            job_ready    <= 1'b1;
            job_busy     <= 1'b0;
            job_done     <= 1'b0;
            job_err      <= 2'd0;
            dma_write    <= 1'b0;
            dma_select   <= 3'd0;
            dma_data     <= '0;
            tensor_start <= 1'b0;
            tensor_relu  <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            dim_q        <= dim_n;
            a_q          <= a_n;
            b_q          <= b_n;
            c_q          <= c_n;
            relu_q       <= relu_n;
            job_ready    <= (state_n == S_IDLE);
            job_busy     <= (state_n != S_IDLE);
            job_done     <= (state_n == S_DONE);
            job_err      <= err_n;
            dma_write    <= wr_n;
            if (wr_n) begin
                dma_select <= sel_c;
                dma_data   <= data_c;
            end
            tensor_start <= (state_n == S_START);
            tensor_relu  <= (state_n != S_IDLE) && relu_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ast_tensor_job_sequencer.sv
// tb_ast_tensor_job_sequencer: randomized jobs against a cycle-arithmetic job model,
// with a bench-side DMA/tensor responder driven by per-phase latencies.
`default_nettype none

module tb_ast_tensor_job_sequencer;

    localparam int SIZE = 4;
    localparam int DWID = 14;
    localparam int TO   = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            job_valid = 1'b0;
    logic            job_ready;
    logic [DWID-1:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic [2:0]      dim = '0;
    logic            relu_en = 1'b0;
    logic            dma_write;
    logic [2:0]      dma_select;
    logic [DWID-1:0] dma_data;
    logic            dma_fin_transfer = 1'b0;
    logic            tensor_start;
    logic            tensor_relu;
    logic            tensor_done = 1'b0;
    logic            job_busy;
    logic            job_done;
    logic [1:0]      job_err;

    ast_tensor_job_sequencer #(.SIZE(SIZE), .DATAWIDTH(DWID), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .dim(dim), .relu_en(relu_en),
        .dma_write(dma_write), .dma_select(dma_select), .dma_data(dma_data),
        .dma_fin_transfer(dma_fin_transfer), .tensor_start(tensor_start),
        .tensor_relu(tensor_relu), .tensor_done(tensor_done), .job_busy(job_busy),
        .job_done(job_done), .job_err(job_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int acc_q[$], done_q[$], err_q[$], start_q[$];
    logic [16:0] wr_q[$], exp_w[$];
    int busy_bad = 0, stab_bad = 0;
    int lat_tab[3];
    int tlat;
    int go_n = 0, go_cyc = 0, st_cyc = 0;
    bit have_go = 0, have_st = 0, in_job = 0, pend = 0, cur_relu = 0;
    logic [16:0] prev_sd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observer and DMA/tensor responder; cycle numbers count negative edges.
    initial begin
        int lat;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                in_job = 0; pend = 0; have_go = 0; have_st = 0;
                dma_fin_transfer = 1'b0; tensor_done = 1'b0; prev_sd = '0;
            end else begin
                if (pend) begin in_job = 1; pend = 0; end
                if (job_busy !== in_job) busy_bad++;
                if (job_ready !== !job_busy) busy_bad++;
                if (tensor_relu !== (job_busy & cur_relu)) busy_bad++;
                if (!dma_write && {dma_select, dma_data} !== prev_sd) stab_bad++;
                prev_sd = {dma_select, dma_data};
                if (dma_write) begin
                    wr_q.push_back({dma_select, dma_data});
                    if (dma_select == 3'd3) begin go_n++; go_cyc = cyc; have_go = 1; end
                end
                if (tensor_start) begin start_q.push_back(cyc); st_cyc = cyc; have_st = 1; end
                if (job_done) begin done_q.push_back(cyc); err_q.push_back(int'(job_err)); in_job = 0; end
                if (job_valid && job_ready) begin
                    acc_q.push_back(cyc); pend = 1; go_n = 0;
                    have_go = 0; have_st = 0; cur_relu = relu_en;
                end
                if (have_go && cyc > go_cyc) begin
                    lat = (go_n >= 1 && go_n <= 3) ? lat_tab[go_n-1] : 0;
                    if (cyc == go_cyc + 1) dma_fin_transfer = (lat != 0);
                    else dma_fin_transfer = (lat != 0) && (cyc >= go_cyc + lat);
                end
                if (have_st && cyc > st_cyc) begin
                    if (cyc == st_cyc + 1) tensor_done = (tlat != 0);
                    else tensor_done = (tlat != 0) && (cyc >= st_cyc + tlat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(output int acc);
        int n = 0;
        while (acc_q.size() == 0 && n < 50) begin tick(); n++; end
        check("accept_seen", acc_q.size(), 1);
        acc = (acc_q.size() > 0) ? acc_q.pop_front() : 0;
    endtask

    task automatic add_phase(input int p, input int d, input int base);
        exp_w.push_back({3'd0, 14'(d)});
        exp_w.push_back({3'd1, 14'(d)});
        exp_w.push_back({3'd2, 14'(p)});
        exp_w.push_back({3'd4, 14'(base)});
        exp_w.push_back({3'd3, 14'd1});
    endtask

    task automatic check_job(input int acc, input int d, input int a, input int b, input int c,
                             input int la, input int lb, input int lc, input int t,
                             output int dc);
        int edone, eerr, estart, ga, gb, gc, s, n, er;
        exp_w.delete();
        estart = -1;
        if (d == 0 || d > SIZE) begin
            edone = acc + 1; eerr = 1;
        end else begin
            ga = acc + 5; add_phase(0, d, a);
            if (la == 0) begin edone = ga + TO + 1; eerr = 2; end
            else begin
                gb = ga + la + 5; add_phase(1, d, b);
                if (lb == 0) begin edone = gb + TO + 1; eerr = 2; end
                else begin
                    s = gb + lb + 1; estart = s;
                    if (t == 0) begin edone = s + TO + 1; eerr = 3; end
                    else begin
                        gc = s + t + 5; add_phase(2, d, c);
                        if (lc == 0) begin edone = gc + TO + 1; eerr = 2; end
                        else begin edone = gc + lc + 1; eerr = 0; end
                    end
                end
            end
        end
        n = 0;
        while (done_q.size() == 0 && n < 1000) begin tick(); n++; end
        check("done_seen", done_q.size(), 1);
        dc = (done_q.size() > 0) ? done_q.pop_front() : 0;
        er = (err_q.size() > 0) ? err_q.pop_front() : -1;
        check("done_latency", dc - acc, edone - acc);
        check("done_err", er, eerr);
        check("n_writes", wr_q.size(), exp_w.size());
        foreach (exp_w[i])
            if (wr_q.size() > 0) check($sformatf("write%0d", i), wr_q.pop_front(), exp_w[i]);
        wr_q.delete();
        check("n_starts", start_q.size(), (estart >= 0) ? 1 : 0);
        if (estart >= 0 && start_q.size() > 0)
            check("start_cycle", start_q.pop_front() - acc, estart - acc);
        start_q.delete();
        check("busy_ready_relu", busy_bad, 0);
        check("sel_data_stable", stab_bad, 0);
        busy_bad = 0; stab_bad = 0;
        check("post_ready", job_ready, 1);
        check("post_busy", job_busy, 0);
        check("post_relu", tensor_relu, 0);
        check("post_err", job_err, eerr);
    endtask

    task automatic set_desc(input int d, input int a, input int b, input int c, input int r);
        dim = 3'(d); addr_a = 14'(a); addr_b = 14'(b); addr_c = 14'(c); relu_en = 1'(r);
    endtask

    task automatic scramble();
        set_desc($urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic run_job(input int d, input int a, input int b, input int c, input int r,
                           input int la, input int lb, input int lc, input int t);
        int acc, dc;
        lat_tab[0] = la; lat_tab[1] = lb; lat_tab[2] = lc; tlat = t;
        set_desc(d, a, b, c, r);
        job_valid = 1'b1;
        wait_accept(acc);
        job_valid = 1'b0;
        scramble();
        check_job(acc, d, a, b, c, la, lb, lc, t, dc);
    endtask

    initial begin
        int acc1, acc2, dc1, dc2, d, n;
        int a1, b1, c1, a2, b2, c2;
        repeat (3) tick();
        check("rst_ready", job_ready, 1);
        check("rst_busy", job_busy, 0);
        check("rst_outs", {job_done, job_err, dma_write, dma_select, dma_data, tensor_start, tensor_relu}, 0);
        reset = 1'b1;
        tick();

        run_job(4, 'h00, 'h10, 'h20, 0, 8, 8, 8, 20);
        run_job(0, 'h11, 'h22, 'h33, 1, 8, 8, 8, 20);
        run_job(5, 'h11, 'h22, 'h33, 0, 8, 8, 8, 20);
        run_job(7, 'h11, 'h22, 'h33, 0, 8, 8, 8, 20);
        run_job(3, 'h100, 'h200, 'h300, 0, 8, 0, 8, 20);
        run_job(2, 'h40, 'h50, 'h60, 1, 5, 6, 7, 0);

        for (int i = 0; i < 8; i++) begin
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 4);
            run_job(d, $urandom, $urandom, $urandom, $urandom_range(0, 1),
                    $urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12),
                    $urandom_range(2, 25));
        end

        // job_valid held across two back-to-back jobs, descriptor swapped mid-job
        lat_tab[0] = 4; lat_tab[1] = 3; lat_tab[2] = 6; tlat = 9;
        a1 = $urandom; b1 = $urandom; c1 = $urandom;
        a2 = $urandom; b2 = $urandom; c2 = $urandom;
        set_desc(3, a1, b1, c1, 1);
        job_valid = 1'b1;
        wait_accept(acc1);
        set_desc(2, a2, b2, c2, 0);
        check_job(acc1, 3, a1, b1, c1, 4, 3, 6, 9, dc1);
        wait_accept(acc2);
        check("hold_accept_cycle", acc2 - dc1, 1);
        job_valid = 1'b0;
        scramble();
        check_job(acc2, 2, a2, b2, c2, 4, 3, 6, 9, dc2);

        // asynchronous reset in the middle of the tensor wait
        lat_tab[0] = 8; lat_tab[1] = 8; lat_tab[2] = 8; tlat = 0;
        set_desc(4, 'h00, 'h10, 'h20, 1);
        job_valid = 1'b1;
        wait_accept(acc1);
        job_valid = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 200) begin tick(); n++; end
        check("mid_start_seen", start_q.size(), 1);
        repeat (5) tick();
        check("pre_reset_busy", job_busy, 1);
        #1 reset = 1'b0;
        #1;
        check("async_ready", job_ready, 1);
        check("async_busy", job_busy, 0);
        check("async_outs", {job_done, job_err, dma_write, dma_select, dma_data, tensor_start, tensor_relu}, 0);
        repeat (2) tick();
        reset = 1'b1;
        acc_q.delete(); done_q.delete(); err_q.delete(); start_q.delete(); wr_q.delete();
        busy_bad = 0; stab_bad = 0;
        tick();
        run_job(4, 'h00, 'h10, 'h20, 0, 8, 8, 8, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ast_tensor_job_sequencer.md
Name: ast_tensor_job_sequencer

Overview:
- Job-level controller that runs a complete matrix multiply on the tensor subsystem using the DMA engine.
- Accepts one job descriptor: A, B and C base addresses, dimension and relu enable.
- Programs the DMA register file to load A, load B and store C, and pulses tensor start between the loads and the store.
- Sits between the CPU/host job interface and the ast_dma_sv register-write port plus tensor start/done. It replaces testbench-driven register sequencing.

Parameters:
SIZE, 4, systolic array dimension; maximum legal job dimension.
DATAWIDTH, 14, DMA data/address width.
TIMEOUT, 1024, max cycles waited for DMA finished_transfer or tensor done before aborting.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
job_valid  in  1  job descriptor valid.
job_ready  out  1  sequencer can accept a job.
addr_a  in  DATAWIDTH  RAM base address of matrix A.
addr_b  in  DATAWIDTH  RAM base address of matrix B.
addr_c  in  DATAWIDTH  RAM base address for result C.
dim  in  $clog2(SIZE)+1  matrix dimension (depth = width = dim).
relu_en  in  1  apply relu to the result.
dma_write  out  1  DMA register write strobe.
dma_select  out  3  DMA register index.
dma_data  out  DATAWIDTH  DMA register write data.
dma_fin_transfer  in  1  DMA transfer-complete status.
tensor_start  out  1  one-cycle start pulse to the tensor subsystem.
tensor_relu  out  1  relu control, held for the whole job.
tensor_done  in  1  tensor computation complete.
job_busy  out  1  a job is in progress.
job_done  out  1  one-cycle completion pulse.
job_err  out  2  status captured with job_done: 0 ok, 1 bad dim, 2 DMA timeout, 3 tensor timeout.

Behaviour:
- Reset (reset=0, async):
  - State returns to IDLE immediately; no register write is issued on abort.
  - Outputs: job_ready=1, job_busy=0, job_done=0, job_err=0, dma_write=0, dma_select=0, dma_data=0, tensor_start=0, tensor_relu=0.
- Handshake:
  - A job is accepted on the rising edge where job_valid && job_ready.
  - The descriptor and relu_en are registered at accept; inputs are ignored afterwards.
  - job_ready=1 only in IDLE. job_valid while busy has no effect.
- Dimension check at accept: dim==0 or dim>SIZE → no DMA or tensor activity; job_done pulses the next cycle with job_err=1; return to IDLE.
- DMA phase order: LOAD_A (mode 0, addr_a), then LOAD_B (mode 1, addr_b), then COMPUTE, then STORE (mode 2, addr_c).
- Each DMA phase is 5 consecutive cycles with dma_write=1, one register per cycle, in this order:
  - sel 0 = dim (depth)
  - sel 1 = dim (width)
  - sel 2 = mode
  - sel 4 = base address
  - sel 3 = 1 (go)
- WAIT_DMA:
  - dma_write=0.
  - dma_fin_transfer is ignored in the first cycle after the go write (DMA status latency); it is sampled from the second cycle on.
  - A high sample advances to the next phase on the following cycle.
- COMPUTE:
  - tensor_start=1 for exactly one cycle, then WAIT_T.
  - tensor_done is ignored in the cycle after start and sampled thereafter.
  - tensor_done high advances to STORE.
- Timeout counter:
  - Clears on entry to WAIT_DMA/WAIT_T and increments each waiting cycle.
  - Reaching TIMEOUT aborts the job: job_done pulses with job_err=2 (DMA) or 3 (tensor); return to IDLE.
- Completion:
  - Store finished_transfer → job_done=1, job_err=0 for one cycle; IDLE on the next cycle.
  - job_err holds its value until the next accept, where it clears to 0.
- tensor_relu = registered relu_en while job_busy, else 0.
- job_busy=1 from the cycle after accept until the cycle of job_done, inclusive.
- dma_select/dma_data hold their last value when dma_write=0 (values are don't-care, but must be stable).
- Minimum job latency, accept → job_done: 3×(5 writes + ≥2 wait) + 1 start + ≥2 wait + 1 cycles.

Test Plan:
- Nominal job, dim=4, addr_a=0x00, addr_b=0x10, addr_c=0x20, relu_en=0, DMA finishes 8 cycles after each go, tensor done 20 cycles after start:
  - Writes are exactly (0,4)(1,4)(2,0)(4,0x00)(3,1), then (0,4)(1,4)(2,1)(4,0x10)(3,1), then (0,4)(1,4)(2,2)(4,0x20)(3,1).
  - One tensor_start pulse between load B and store.
  - job_done pulses once with job_err=0.
- dim=0, then dim=5 with SIZE=4 → job_done the next cycle with job_err=1; zero dma_write or tensor_start cycles; job_ready back to 1.
- dma_fin_transfer held low during LOAD_B, TIMEOUT=64 → job_done with job_err=2 exactly 64 waiting cycles after the LOAD_B go write; no STORE writes.
- tensor_done never asserted, TIMEOUT=64 → job_err=3; no STORE writes; relu_en=1 keeps tensor_relu=1 until job_done, then 0.
- job_valid held high continuously → second job accepted only the cycle after the first job_done; descriptor changes mid-job do not alter the write data.
- reset driven low mid-WAIT_T and asynchronously to clk → all outputs reach reset values before the next edge; a new job after release runs the nominal sequence.
